// File: rtl/exc_ctrl.sv
// Exception sequencer between MEM and CP0: picks the winning cause by fixed priority,
// waits for the bus to drain, then issues a one-cycle CP0 command with flush and redirect.
//
// state  | meaning
// IDLE   | watching the MEM-stage instruction for an exception or interrupt
// DRAIN  | cause captured, pipeline held until outstanding AXI traffic finishes
// COMMIT | one-cycle command to CP0 plus flush and PC redirect
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [31:0] mem_mem_addr_i,
  input  logic        exc_adel_if_i,
  input  logic        exc_ri_i,
  input  logic        exc_ov_i,
  input  logic        exc_sys_i,
  input  logic        exc_bp_i,
  input  logic        exc_adel_ld_i,
  input  logic        exc_ades_i,
  input  logic        exc_eret_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_waddr_i,
  input  logic [31:0] cp0_wdata_i,
  input  logic        bus_busy_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] code_q, code_d;
  logic [31:0] pc_q, pc_d;
  logic        ds_q, ds_d;
  logic [31:0] bad_q, bad_d;
  logic [31:0] tgt_q, tgt_d;

  logic [31:0] eff_status, eff_cause, eff_epc;
  logic        int_pending;
  logic        cause_any;
  logic [31:0] sel_code, sel_bad, sel_tgt;

  // A WB-stage mtc0 lands in CP0 this same edge, so forward it to avoid a stale decision.
  always_comb begin
    eff_status = cp0_status_i;
    eff_cause  = cp0_cause_i;
    eff_epc    = cp0_epc_i;
    if (cp0_we_i && cp0_waddr_i == 5'd12) eff_status = cp0_wdata_i;
    if (cp0_we_i && cp0_waddr_i == 5'd13) eff_cause[9:8] = cp0_wdata_i[9:8];
    if (cp0_we_i && cp0_waddr_i == 5'd14) eff_epc = cp0_wdata_i;
  end

  assign int_pending = eff_status[0] & ~eff_status[1] &
                       (|(eff_cause[15:8] & eff_status[15:8]));

  always_comb begin
    sel_code  = 32'h0;
    sel_bad   = 32'h0;
    sel_tgt   = EXC_VECTOR;
    cause_any = 1'b1;
    if (int_pending)        sel_code = 32'h1;
    else if (exc_adel_if_i) begin
      sel_code = 32'h4;
      sel_bad  = mem_pc_i;
    end
    else if (exc_ri_i)      sel_code = 32'ha;
    else if (exc_ov_i)      sel_code = 32'hc;
    else if (exc_sys_i)     sel_code = 32'h8;
    else if (exc_bp_i)      sel_code = 32'h9;
    else if (exc_adel_ld_i) begin
      sel_code = 32'h4;
      sel_bad  = mem_mem_addr_i;
    end
    else if (exc_ades_i) begin
      sel_code = 32'h5;
      sel_bad  = mem_mem_addr_i;
    end
    else if (exc_eret_i) begin
      sel_code = 32'he;
      sel_tgt  = eff_epc;
    end
    else cause_any = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    pc_d    = pc_q;
    ds_d    = ds_q;
    bad_d   = bad_q;
    tgt_d   = tgt_q;
    case (state_q)
      IDLE: begin
        if (mem_valid_i && cause_any) begin
          code_d  = sel_code;
          pc_d    = mem_pc_i;
          ds_d    = mem_in_delayslot_i;
          bad_d   = sel_bad;
          tgt_d   = sel_tgt;
          state_d = bus_busy_i ? DRAIN : COMMIT;
        end
      end
      DRAIN:   if (!bus_busy_i) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= 32'h0;
      pc_q    <= 32'h0;
      ds_q    <= 1'b0;
      bad_q   <= 32'h0;
      tgt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pc_q    <= pc_d;
      ds_q    <= ds_d;
      bad_q   <= bad_d;
      tgt_q   <= tgt_d;
    end
  end

  // Outputs decode only flops, so CP0 sees glitch-free values at the negedge.
  assign excepttype_o        = (state_q == COMMIT) ? code_q : 32'h0;
  assign flush_o             = (state_q == COMMIT);
  assign redirect_valid_o    = (state_q == COMMIT);
  assign stall_o             = (state_q == DRAIN);
  assign current_inst_addr_o = pc_q;
  assign is_in_delayslot_o   = ds_q;
  assign bad_addr_o          = bad_q;
  assign redirect_pc_o       = tgt_q;

  logic unused_bits;
  assign unused_bits = ^{eff_status[31:16], eff_cause[31:16], eff_cause[7:0]};

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: a table of single-event vectors on an idle bus,
// plus hand-written drain and reset-during-drain sequences.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delayslot_i;
  logic [31:0] mem_mem_addr_i;
  logic        exc_adel_if_i, exc_ri_i, exc_ov_i, exc_sys_i;
  logic        exc_bp_i, exc_adel_ld_i, exc_ades_i, exc_eret_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic        cp0_we_i;
  logic [4:0]  cp0_waddr_i;
  logic [31:0] cp0_wdata_i;
  logic        bus_busy_i;
  logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, redirect_pc_o;
  logic        is_in_delayslot_o, stall_o, flush_o, redirect_valid_o;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [7:0] F_ADEL_IF = 8'h80, F_RI = 8'h40, F_OV = 8'h20, F_SYS = 8'h10,
                         F_BP = 8'h08, F_ADEL_LD = 8'h04, F_ADES = 8'h02, F_ERET = 8'h01;
  localparam logic [31:0] VEC = 32'hBFC00380;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i),
    .mem_in_delayslot_i(mem_in_delayslot_i), .mem_mem_addr_i(mem_mem_addr_i),
    .exc_adel_if_i(exc_adel_if_i), .exc_ri_i(exc_ri_i), .exc_ov_i(exc_ov_i),
    .exc_sys_i(exc_sys_i), .exc_bp_i(exc_bp_i), .exc_adel_ld_i(exc_adel_ld_i),
    .exc_ades_i(exc_ades_i), .exc_eret_i(exc_eret_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
    .cp0_we_i(cp0_we_i), .cp0_waddr_i(cp0_waddr_i), .cp0_wdata_i(cp0_wdata_i),
    .bus_busy_i(bus_busy_i),
    .excepttype_o(excepttype_o), .current_inst_addr_o(current_inst_addr_o),
    .is_in_delayslot_o(is_in_delayslot_o), .bad_addr_o(bad_addr_o),
    .stall_o(stall_o), .flush_o(flush_o), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] addr;
    logic [7:0]  flags;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] exp_code;
    logic [31:0] exp_bad;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_valid_i = 1'b0; mem_pc_i = 32'h0; mem_in_delayslot_i = 1'b0; mem_mem_addr_i = 32'h0;
    {exc_adel_if_i, exc_ri_i, exc_ov_i, exc_sys_i,
     exc_bp_i, exc_adel_ld_i, exc_ades_i, exc_eret_i} = 8'h0;
    cp0_status_i = 32'h0; cp0_cause_i = 32'h0; cp0_epc_i = 32'h0;
    cp0_we_i = 1'b0; cp0_waddr_i = 5'd0; cp0_wdata_i = 32'h0;
    bus_busy_i = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    mem_valid_i = v.valid; mem_pc_i = v.pc; mem_in_delayslot_i = v.ds; mem_mem_addr_i = v.addr;
    {exc_adel_if_i, exc_ri_i, exc_ov_i, exc_sys_i,
     exc_bp_i, exc_adel_ld_i, exc_ades_i, exc_eret_i} = v.flags;
    cp0_status_i = v.status; cp0_cause_i = v.cause; cp0_epc_i = v.epc;
    cp0_we_i = v.we; cp0_waddr_i = v.waddr; cp0_wdata_i = v.wdata;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " excepttype"}, excepttype_o, 32'h0);
    chk({tag, " flush"}, {31'h0, flush_o}, 32'h0);
    chk({tag, " stall"}, {31'h0, stall_o}, 32'h0);
    chk({tag, " redirect_valid"}, {31'h0, redirect_valid_o}, 32'h0);
    chk({tag, " redirect_pc"}, redirect_pc_o, 32'h0);
    chk({tag, " inst_addr"}, current_inst_addr_o, 32'h0);
    chk({tag, " bad_addr"}, bad_addr_o, 32'h0);
    chk({tag, " delayslot"}, {31'h0, is_in_delayslot_o}, 32'h0);
  endtask

  initial begin
    //            valid pc            ds   addr          flags                   status        cause         epc         we   waddr  wdata        code    bad           tgt
    vecs[0]  = '{1'b1, 32'hBFC00100, 1'b0, 32'h0,       F_SYS,                  32'h0,        32'h0,        32'h0,      1'b0, 5'd0,  32'h0,       32'h8,  32'h0,        VEC};
    vecs[1]  = '{1'b1, 32'h00000400, 1'b0, 32'h55,      F_OV | F_SYS | F_ADES,  32'h0,        32'h0,        32'h0,      1'b0, 5'd0,  32'h0,       32'hc,  32'h0,        VEC};
    vecs[2]  = '{1'b1, 32'h00000500, 1'b0, 32'h1003,    F_ADEL_LD,              32'h0,        32'h0,        32'h0,      1'b0, 5'd0,  32'h0,       32'h4,  32'h1003,     VEC};
    vecs[3]  = '{1'b1, 32'h00000002, 1'b0, 32'h0,       F_ADEL_IF,              32'h0,        32'h0,        32'h0,      1'b0, 5'd0,  32'h0,       32'h4,  32'h2,        VEC};
    vecs[4]  = '{1'b1, 32'h00000600, 1'b1, 32'h0,       8'h0,                   32'h0000FF01, 32'h00000400, 32'h0,      1'b0, 5'd0,  32'h0,       32'h1,  32'h0,        VEC};
    vecs[5]  = '{1'b1, 32'h00000604, 1'b0, 32'h0,       8'h0,                   32'h0000FF03, 32'h00000400, 32'h0,      1'b0, 5'd0,  32'h0,       32'h0,  32'h0,        VEC};
    vecs[6]  = '{1'b1, 32'h00000608, 1'b0, 32'h0,       8'h0,                   32'h0,        32'h00000400, 32'h0,      1'b1, 5'd12, 32'hFF01,    32'h1,  32'h0,        VEC};
    vecs[7]  = '{1'b1, 32'h00000700, 1'b0, 32'h0,       F_ERET,                 32'h0,        32'h0,        32'h100,    1'b1, 5'd14, 32'h200,     32'he,  32'h0,        32'h200};
    vecs[8]  = '{1'b1, 32'h00000704, 1'b1, 32'h0,       F_RI | F_BP | F_ERET,   32'h0,        32'h0,        32'h100,    1'b0, 5'd0,  32'h0,       32'ha,  32'h0,        VEC};
    vecs[9]  = '{1'b1, 32'h00000008, 1'b0, 32'h0,       F_ADEL_IF,              32'h0000FF01, 32'h00000400, 32'h0,      1'b0, 5'd0,  32'h0,       32'h1,  32'h0,        VEC};
    vecs[10] = '{1'b1, 32'h00000800, 1'b0, 32'h0,       8'h0,                   32'h00000301, 32'h0,        32'h0,      1'b1, 5'd13, 32'h200,     32'h1,  32'h0,        VEC};
    vecs[11] = '{1'b0, 32'h00000804, 1'b0, 32'h0,       F_SYS,                  32'h0,        32'h0,        32'h0,      1'b0, 5'd0,  32'h0,       32'h0,  32'h0,        VEC};
    vecs[12] = '{1'b1, 32'h00000900, 1'b0, 32'h0,       F_BP,                   32'h0,        32'h0,        32'h0,      1'b0, 5'd0,  32'h0,       32'h9,  32'h0,        VEC};
    vecs[13] = '{1'b1, 32'h00000904, 1'b0, 32'h2002,    F_ADES | F_ERET,        32'h0,        32'h0,        32'h300,    1'b0, 5'd0,  32'h0,       32'h5,  32'h2002,     VEC};

    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d excepttype", i), excepttype_o, vecs[i].exp_code);
      chk($sformatf("v%0d flush", i), {31'h0, flush_o}, {31'h0, vecs[i].exp_code != 0});
      chk($sformatf("v%0d redirect_valid", i), {31'h0, redirect_valid_o}, {31'h0, vecs[i].exp_code != 0});
      chk($sformatf("v%0d stall", i), {31'h0, stall_o}, 32'h0);
      if (vecs[i].exp_code != 0) begin
        chk($sformatf("v%0d inst_addr", i), current_inst_addr_o, vecs[i].pc);
        chk($sformatf("v%0d delayslot", i), {31'h0, is_in_delayslot_o}, {31'h0, vecs[i].ds});
        chk($sformatf("v%0d bad_addr", i), bad_addr_o, vecs[i].exp_bad);
        chk($sformatf("v%0d redirect_pc", i), redirect_pc_o, vecs[i].exp_tgt);
      end
      idle_inputs();
      @(negedge clk);
      chk($sformatf("v%0d after excepttype", i), excepttype_o, 32'h0);
      chk($sformatf("v%0d after flush", i), {31'h0, flush_o}, 32'h0);
    end

    // Drain: busy sampled high on three edges, inputs changed mid-drain must be ignored.
    @(negedge clk);
    mem_valid_i = 1'b1; exc_ri_i = 1'b1; mem_pc_i = 32'hA000; mem_in_delayslot_i = 1'b1;
    bus_busy_i = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("drain c%0d stall", c), {31'h0, stall_o}, 32'h1);
      chk($sformatf("drain c%0d flush", c), {31'h0, flush_o}, 32'h0);
      chk($sformatf("drain c%0d excepttype", c), excepttype_o, 32'h0);
      exc_ri_i = 1'b0; exc_sys_i = 1'b1; mem_pc_i = 32'hB000; mem_in_delayslot_i = 1'b0;
      if (c == 3) bus_busy_i = 1'b0;
    end
    @(negedge clk);
    idle_inputs();
    chk("drain commit excepttype", excepttype_o, 32'ha);
    chk("drain commit stall", {31'h0, stall_o}, 32'h0);
    chk("drain commit flush", {31'h0, flush_o}, 32'h1);
    chk("drain commit inst_addr", current_inst_addr_o, 32'hA000);
    chk("drain commit delayslot", {31'h0, is_in_delayslot_o}, 32'h1);
    chk("drain commit redirect_pc", redirect_pc_o, VEC);
    @(negedge clk);
    chk("drain after excepttype", excepttype_o, 32'h0);
    chk("drain after flush", {31'h0, flush_o}, 32'h0);

    // Reset asserted during the second drain cycle must cancel the command.
    @(negedge clk);
    mem_valid_i = 1'b1; exc_ri_i = 1'b1; mem_pc_i = 32'hC000; bus_busy_i = 1'b1;
    @(negedge clk);
    idle_inputs();
    bus_busy_i = 1'b1;
    chk("rstdrain c1 stall", {31'h0, stall_o}, 32'h1);
    @(negedge clk);
    chk("rstdrain c2 stall", {31'h0, stall_o}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus_busy_i = 1'b0;
    chk_all_zero("rstdrain");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rstdrain post%0d excepttype", c), excepttype_o, 32'h0);
      chk($sformatf("rstdrain post%0d flush", c), {31'h0, flush_o}, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception sequencer between the MEM stage and the CP0 register block. Each cycle it inspects the MEM-stage instruction's exception flags and the CP0 interrupt state, then picks one winning cause by fixed priority. It waits for outstanding AXI bus transactions to drain, then issues a one-cycle exception command to CP0 together with a pipeline flush and a PC redirect (to the handler vector, or to EPC for eret).

## Interface
- EXC_VECTOR, 32'hBFC00380, redirect target for every cause except eret
- clk  in  1  system clock; CP0 samples outputs on the following negedge
- rst  in  1  reset, synchronous, active-high
- mem_valid_i  in  1  MEM stage holds a real instruction, not a bubble
- mem_pc_i  in  32  PC of the MEM-stage instruction
- mem_in_delayslot_i  in  1  MEM-stage instruction sits in a delay slot
- mem_mem_addr_i  in  32  load/store effective address
- exc_adel_if_i, exc_ri_i, exc_ov_i, exc_sys_i, exc_bp_i, exc_adel_ld_i, exc_ades_i, exc_eret_i  in  1 each  per-cause flags from upstream stages
- cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  current CP0 register values
- cp0_we_i  in  1  a WB-stage mtc0 is writing CP0 this cycle
- cp0_waddr_i  in  5  register address of that mtc0 write
- cp0_wdata_i  in  32  data of that mtc0 write
- bus_busy_i  in  1  an AXI transaction is outstanding
- excepttype_o  out  32  exception code to CP0, nonzero for exactly one cycle per event
- current_inst_addr_o  out  32  PC of the excepting instruction
- is_in_delayslot_o  out  1  delay-slot flag of the excepting instruction
- bad_addr_o  out  32  faulting address
- stall_o  out  1  hold IF..MEM stages
- flush_o  out  1  kill IF..MEM stages
- redirect_valid_o  out  1  load redirect_pc_o into the PC
- redirect_pc_o  out  32  redirect target

## Operation
- Bypass values:
  - eff_status = cp0_wdata_i when cp0_we_i and waddr==12, else cp0_status_i.
  - eff_epc = wdata when waddr==14, else cp0_epc_i.
  - eff_cause[9:8] = wdata[9:8] when waddr==13.
- int_pending = eff_status[0] & ~eff_status[1] & |(eff_cause[15:8] & eff_status[15:8]). It only counts when mem_valid_i=1.
- Priority and codes, highest first: interrupt 0x1, adel_if 0x4, ri 0xa, ov 0xc, sys 0x8, bp 0x9, adel_ld 0x4, ades 0x5, eret 0xe. Only the highest present cause is reported.
- bad_addr:
  - adel_if: mem_pc_i.
  - adel_ld and ades: mem_mem_addr_i.
  - Any other cause: 0.
- Redirect target: eret gives eff_epc; any other cause gives EXC_VECTOR.
- FSM states: IDLE, DRAIN, COMMIT.
  - IDLE: when mem_valid_i and any cause is present, capture code, pc, delay-slot flag, bad_addr and target into registers. Go to COMMIT if bus_busy_i=0, else to DRAIN.
  - DRAIN: stall_o=1. Stay while bus_busy_i=1; go to COMMIT the cycle after it falls.
  - COMMIT: drive excepttype_o=captured code, flush_o=1, redirect_valid_o=1 and the captured fields. Return to IDLE.
- Outside COMMIT, excepttype_o, flush_o and redirect_valid_o are all 0.
- Captured fields stay stable through DRAIN and COMMIT. Input changes during DRAIN are ignored.
- Reset (including mid-DRAIN or mid-COMMIT) returns the FSM to IDLE and zeroes every output, with no command issued.

## Timing
- All outputs are registered.
- Detection at posedge N gives COMMIT outputs during cycle N+1 when the bus is idle. With drain they appear during cycle N+k+1, where bus_busy_i is first sampled 0 at posedge N+k.
- stall_o is asserted from cycle N+1 through the last DRAIN cycle. stall_o and flush_o are never high together.
- The cycle after COMMIT is IDLE. The flushed bubble has mem_valid_i=0, so there is no immediate re-detection.
- Because CP0 sets EXL on the COMMIT negedge, a held interrupt is masked from the next posedge onward.

## Test plan
- Sys exception: mem_valid=1, exc_sys=1, pc=0xBFC00100, not in delay slot, bus idle -> next cycle excepttype_o=0x8, current_inst_addr_o=0xBFC00100, flush_o=1, redirect_pc_o=0xBFC00380, for exactly one cycle.
- Priority: ov+sys+ades at once -> 0xc. Load misaligned at addr 0x1003 -> 0x4 with bad_addr_o=0x1003. Fetch misaligned at pc=0x2 -> 0x4 with bad_addr_o=0x2.
- Interrupt: status=0x0000FF01, cause[15:8]=0x04 -> 0x1. Same with status[1]=1 -> no event. With status[0]=0 but an mtc0 writing status=0xFF01 in the same cycle -> 0x1.
- eret: cp0_epc=0x100, mtc0 writing EPC=0x200 in the same cycle -> excepttype_o=0xe, redirect_pc_o=0x200.
- Drain: exc_ri with bus_busy high for 3 cycles -> stall_o high 3 cycles, then one COMMIT cycle with 0xa. Asserting rst in cycle 2 -> no COMMIT, all outputs 0.
